div4s_radix2_seq: RTL and testbench

Sequential signed divider and inverse of the 4-bit signed multiplier blocks. Divides a 2W-bit signed dividend (a multiplier product) by a W-bit signed divisor (a multiplier operand), one quotient bit per cycle, using radix-2 restoring long division on magnitudes. Returns a W-bit quotient and remainder with overflow and divide-by-zero flags. Used with the multiplier wrappers for round-trip checks (product / multiplier == multiplicand), and as a standalone arithmetic unit behind valid/ready handshakes.

---
 rtl/div4s_radix2_seq.sv | 137 +++++++++++++
 tb/tb_div4s_radix2_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div4s_radix2_seq.sv
// ============================================================================
// Module   : div4s_radix2_seq
// Purpose  : Sequential signed 2W/W divider, radix-2 restoring on magnitudes,
//            valid/ready handshakes, saturating quotient with overflow flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div4s_radix2_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               overflow,
  output logic               div_by_zero
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0]    CNT_LOAD  = CW'(DW);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [DW-1:0]    POS_LIMIT = DW'((1 << (WIDTH - 1)) - 1);
  localparam logic [DW-1:0]    NEG_LIMIT = DW'(1 << (WIDTH - 1));
  localparam logic [WIDTH-1:0] SAT_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [DW-1:0]    quo;       // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] prem;      // partial remainder
  logic [WIDTH-1:0] dsr;
  logic             qsign;
  logic             rsign;
  logic             zero_div;

  logic             accept;
  logic [DW-1:0]    dvd_abs;
  logic [WIDTH-1:0] dsr_abs;
  logic [WIDTH:0]   shifted;
  logic             qbit;
  logic [WIDTH-1:0] prem_next;
  logic             ovf;
  logic [WIDTH-1:0] q_low;

  assign accept    = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign dvd_abs = dividend[DW-1] ? -dividend : dividend;
  assign dsr_abs = divisor[WIDTH-1] ? -divisor : divisor;

  // Trial subtraction; prem < dsr <= 2^(W-1) keeps the kept value within W bits.
  assign shifted   = {prem, quo[DW-1]};
  assign qbit      = (shifted >= {1'b0, dsr});
  assign prem_next = WIDTH'(qbit ? (shifted - {1'b0, dsr}) : shifted);

  assign ovf   = qsign ? (quo > NEG_LIMIT) : (quo > POS_LIMIT);
  assign q_low = quo[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid)          state_next = CALC;
      CALC: if (count == CNT_ONE)  state_next = FIX;
      FIX:                         state_next = DONE;
      DONE: if (out_ready)         state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      quo         <= '0;
      prem        <= '0;
      dsr         <= '0;
      qsign       <= 1'b0;
      rsign       <= 1'b0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        quo      <= dvd_abs;
        prem     <= '0;
        dsr      <= dsr_abs;
        qsign    <= dividend[DW-1] ^ divisor[WIDTH-1];
        rsign    <= dividend[DW-1];
        zero_div <= (divisor == '0);
        count    <= CNT_LOAD;
      end else if (state == CALC) begin
        quo   <= {quo[DW-2:0], qbit};
        prem  <= prem_next;
        count <= count - CNT_ONE;
      end else if (state == FIX) begin
        if (zero_div) begin
          quotient    <= '0;
          remainder   <= '0;
          overflow    <= 1'b0;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= ovf ? (qsign ? SAT_NEG : SAT_POS)
                             : (qsign ? -q_low : q_low);
          remainder   <= rsign ? -prem : prem;
          overflow    <= ovf;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div4s_radix2_seq.sv
// ============================================================================
// Module   : tb_div4s_radix2_seq
// Purpose  : Self-checking bench for div4s_radix2_seq (vectors, corners, random).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div4s_radix2_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       overflow;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div4s_radix2_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [7:0] dd;
    logic [3:0] ds;
    logic [3:0] q;
    logic [3:0] r;
    logic       ov;
    logic       dz;
  } vec_t;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       ov;
    logic       dz;
  } res_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, then saturate.
  function automatic res_t model(input logic [7:0] dd, input logic [3:0] ds);
    res_t res;
    int sd, sv, tq, tr;
    sd = $signed(dd);
    sv = $signed(ds);
    if (sv == 0) begin
      res.q = 4'h0; res.r = 4'h0; res.ov = 1'b0; res.dz = 1'b1;
    end else begin
      tq = sd / sv;
      tr = sd % sv;
      res.dz = 1'b0;
      res.ov = (tq > 7) || (tq < -8);
      res.q  = res.ov ? ((tq > 0) ? 4'h7 : 4'h8) : 4'(tq);
      res.r  = 4'(tr);
    end
    return res;
  endfunction

  task automatic wait_result(input int start, input string nm);
    int lat;
    lat = start;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, 9);
  endtask

  task automatic launch(input logic [7:0] dd, input logic [3:0] ds);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("in_ready timeout", 0, 1);
    in_valid = 1'b1; dividend = dd; divisor = ds;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_result(input int stall);
    logic [3:0] q0, r0;
    q0 = quotient; r0 = remainder;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall out_valid", int'(out_valid), 1);
      chk("stall quotient", int'(quotient), int'(q0));
      chk("stall remainder", int'(remainder), int'(r0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post handshake out_valid", int'(out_valid), 0);
  endtask

  task automatic do_op(input logic [7:0] dd, input logic [3:0] ds, input res_t exp,
                       input int stall, input string nm);
    launch(dd, ds);
    wait_result(0, nm);
    chk({nm, " quotient"}, int'(quotient), int'(exp.q));
    chk({nm, " remainder"}, int'(remainder), int'(exp.r));
    chk({nm, " overflow"}, int'(overflow), int'(exp.ov));
    chk({nm, " div_by_zero"}, int'(div_by_zero), int'(exp.dz));
    release_result(stall);
  endtask

  vec_t vecs[14];

  initial begin
    res_t e;
    logic [7:0] prod;
    logic [3:0] mcand, mplier;
    bit         seen;

    vecs[0]  = '{8'h2A, 4'h6, 4'h7, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{8'hD5, 4'h6, 4'h9, 4'hF, 1'b0, 1'b0};
    vecs[2]  = '{8'h40, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 4'hF, 4'h7, 4'h0, 1'b1, 1'b0};
    vecs[4]  = '{8'h11, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[5]  = '{8'h07, 4'hD, 4'hE, 4'h1, 1'b0, 1'b0};
    vecs[6]  = '{8'hF9, 4'h3, 4'hE, 4'hF, 1'b0, 1'b0};
    vecs[7]  = '{8'h7F, 4'h7, 4'h7, 4'h1, 1'b1, 1'b0};
    vecs[8]  = '{8'h81, 4'h8, 4'h7, 4'h9, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0};
    vecs[10] = '{8'hC0, 4'h8, 4'h7, 4'h0, 1'b1, 1'b0};
    vecs[11] = '{8'hC8, 4'h7, 4'h8, 4'h0, 1'b0, 1'b0};
    vecs[12] = '{8'h80, 4'h1, 4'h8, 4'h0, 1'b1, 1'b0};
    vecs[13] = '{8'h7F, 4'h8, 4'h8, 4'h7, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = 8'h00; divisor = 4'h0;
    #12;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset quotient", int'(quotient), 0);
    chk("reset remainder", int'(remainder), 0);
    chk("reset overflow", int'(overflow), 0);
    chk("reset div_by_zero", int'(div_by_zero), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      e.q = vecs[i].q; e.r = vecs[i].r; e.ov = vecs[i].ov; e.dz = vecs[i].dz;
      do_op(vecs[i].dd, vecs[i].ds, e, i % 3, $sformatf("vec%0d", i));
    end

    // Backpressure with fresh operands presented while DONE.
    launch(8'h2A, 4'h6);
    wait_result(0, "bp first");
    begin
      logic [3:0] q0, r0;
      q0 = quotient; r0 = remainder;
      in_valid = 1'b1; dividend = 8'hC8; divisor = 4'h7;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        chk("bp out_valid", int'(out_valid), 1);
        chk("bp in_ready", int'(in_ready), 0);
        chk("bp quotient", int'(quotient), int'(q0));
        chk("bp remainder", int'(remainder), int'(r0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp idle out_valid", int'(out_valid), 0);
      chk("bp idle in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp accepted", int'(in_ready), 0);
      wait_result(0, "bp second");
      chk("bp second quotient", int'(quotient), 8);
      chk("bp second remainder", int'(remainder), 0);
      release_result(0);
    end

    // Reset during CALC: abort with no result afterwards.
    launch(8'h2A, 4'h6);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort out_valid", int'(out_valid), 0);
    chk("abort in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort no result", int'(seen), 0);
    do_op(8'hD5, 4'h6, model(8'hD5, 4'h6), 1, "after abort");

    // Round trip against multiplier products.
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        if (b != 0) begin
          mcand  = 4'(a);
          mplier = 4'(b);
          prod   = 8'(a * b);
          e.q = mcand; e.r = 4'h0; e.ov = 1'b0; e.dz = 1'b0;
          do_op(prod, mplier, e, int'($urandom_range(0, 3)), "roundtrip");
        end
      end
    end

    // Random operands against the reference model.
    for (int i = 0; i < 80; i++) begin
      logic [7:0] dd;
      logic [3:0] ds;
      dd = 8'($urandom);
      ds = 4'($urandom);
      do_op(dd, ds, model(dd, ds), int'($urandom_range(0, 2)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
